// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// Receive-side bundle: serial line in, byte/word/error strobes out.
interface uart_rx_word_if;
  logic        uart_rx;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [15:0] word_out;
  logic        word_valid;
  logic        frame_err;
  logic        seq_err;

  modport master (
    input  uart_rx,
    output rx_byte, rx_byte_valid, word_out, word_valid, frame_err, seq_err
  );

  modport slave (
    output uart_rx,
    input  rx_byte, rx_byte_valid, word_out, word_valid, frame_err, seq_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, start/data/stop sampling FSM.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 1_562_500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       idle_o
);
  localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

  logic             sync1_q, sync2_q, line_prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      line_prev_q  <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= rx_i;
      sync2_q      <= sync1_q;
      line_prev_q  <= sync2_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  // A start needs a 1->0 transition, so a held-low line yields a single frame.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (line_prev_q && !sync2_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync2_q) begin
            byte_d       = shreg_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign idle_o       = (state_q == IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// Reassembles received byte pairs (high first) into 16-bit words, with idle resync.
// Optional contiguity check enabled by defining UART_RX_SEQ_CHECK_EN.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 1_562_500,
  parameter int unsigned RESYNC_BITS = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_word_if.master rx_if
);
  localparam int unsigned BIT_CYCLES    = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned RESYNC_CYCLES = RESYNC_BITS * BIT_CYCLES;
  localparam int unsigned RW            = $clog2(RESYNC_CYCLES);
  localparam logic [RW-1:0] RESYNC_LAST = RW'(RESYNC_CYCLES - 1);

  logic [7:0]    byte_w;
  logic          byte_valid_w, frame_err_w, idle_w;
  logic          phase_q, phase_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [15:0]   hold_q, hold_d;
  logic [7:0]    high_q, high_d;
  logic [15:0]   word_cur;
  logic          word_valid_w;
  logic          seq_err_w;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_byte (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_if.uart_rx),
    .byte_o       (byte_w),
    .byte_valid_o (byte_valid_w),
    .frame_err_o  (frame_err_w),
    .idle_o       (idle_w)
  );

  assign word_cur     = {high_q, byte_w};
  assign word_valid_w = byte_valid_w & phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      rcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      phase_q <= phase_d;
      rcnt_q  <= rcnt_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    high_q <= high_d;
  end

  // Resync timer runs only while a high byte is pending and the line is idle.
  always_comb begin
    phase_d = phase_q;
    high_d  = high_q;
    hold_d  = hold_q;
    rcnt_d  = '0;
    if (frame_err_w) begin
      phase_d = 1'b0;
    end else if (byte_valid_w) begin
      if (!phase_q) begin
        high_d  = byte_w;
        phase_d = 1'b1;
      end else begin
        hold_d  = word_cur;
        phase_d = 1'b0;
      end
    end else if (phase_q && idle_w) begin
      if (rcnt_q == RESYNC_LAST) phase_d = 1'b0;
      else                       rcnt_d  = rcnt_q + 1'b1;
    end
  end

`ifdef UART_RX_SEQ_CHECK_EN
  logic [15:0] prev_q;
  logic        first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      first_q <= 1'b0;
    end else if (frame_err_w) begin
      first_q <= 1'b0;
    end else if (word_valid_w) begin
      prev_q  <= word_cur;
      first_q <= 1'b1;
    end
  end

  assign seq_err_w = word_valid_w && first_q && (word_cur != prev_q + 16'd1);
`else
  assign seq_err_w = 1'b0;
`endif

  assign rx_if.rx_byte       = byte_w;
  assign rx_if.rx_byte_valid = byte_valid_w;
  assign rx_if.word_out      = word_valid_w ? word_cur : hold_q;
  assign rx_if.word_valid    = word_valid_w;
  assign rx_if.frame_err     = frame_err_w;
  assign rx_if.seq_err       = seq_err_w;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word with a byte/word/error expectation model.
module tb_uart_rx_word;
  localparam int BIT         = 32;
  localparam int RESYNC_BITS = 20;
`ifdef UART_RX_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  uart_rx_word_if rx_if ();

  uart_rx_word dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (rx_if)
  );

  int errors = 0;
  int checks = 0;

  // expectation model
  logic [7:0]  exp_byte[$];
  logic [15:0] exp_word[$];
  bit          exp_seq[$];
  int          exp_fe = 0;
  bit          m_phase = 1'b0;
  bit          m_first = 1'b0;
  logic [7:0]  m_high = '0;
  logic [15:0] m_prev = '0;

  // observed activity
  int          n_byte = 0, n_word = 0, n_fe = 0, n_seq = 0;
  logic [15:0] last_word = '0;
  logic [7:0]  last_byte = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0]  eb;
    logic [15:0] ew;
    bit          es;
    if (!rst_n) begin
      check("outputs_in_reset",
            int'({rx_if.rx_byte, rx_if.rx_byte_valid, rx_if.word_valid,
                  rx_if.frame_err, rx_if.seq_err}) + int'(rx_if.word_out), 0);
      return;
    end
    if (rx_if.rx_byte_valid) begin
      n_byte++;
      last_byte = rx_if.rx_byte;
      if (exp_byte.size() == 0) check("unexpected_byte", int'(rx_if.rx_byte), -1);
      else begin
        eb = exp_byte.pop_front();
        check("rx_byte", int'(rx_if.rx_byte), int'(eb));
      end
    end
    if (rx_if.word_valid) begin
      n_word++;
      last_word = rx_if.word_out;
      check("word_with_byte", int'(rx_if.rx_byte_valid), 1);
      if (exp_word.size() == 0) check("unexpected_word", int'(rx_if.word_out), -1);
      else begin
        ew = exp_word.pop_front();
        es = exp_seq.pop_front();
        check("word_out", int'(rx_if.word_out), int'(ew));
        check("seq_err", int'(rx_if.seq_err), int'(es));
      end
    end
    if (rx_if.seq_err) begin
      n_seq++;
      if (!rx_if.word_valid) check("seq_without_word", 1, 0);
    end
    if (rx_if.frame_err) begin
      n_fe++;
      if (exp_fe == 0) check("unexpected_frame_err", 1, 0);
      else begin
        exp_fe--;
        check("frame_err_expected", 1, 1 - int'(rx_if.rx_byte_valid));
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic model_reset();
    m_phase = 1'b0;
    m_first = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [15:0] w;
    if (stop) begin
      exp_byte.push_back(b);
      if (!m_phase) begin
        m_high  = b;
        m_phase = 1'b1;
      end else begin
        w = {m_high, b};
        exp_word.push_back(w);
        exp_seq.push_back(SEQ_EN && m_first && (int'(w) != (int'(m_prev) + 1) % 65536));
        m_prev  = w;
        m_first = 1'b1;
        m_phase = 1'b0;
      end
    end else begin
      exp_fe++;
      m_phase = 1'b0;
      m_first = 1'b0;
    end
    rx_if.uart_rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_if.uart_rx = b[i];
      tick(BIT);
    end
    rx_if.uart_rx = stop;
    tick(BIT);
    rx_if.uart_rx = 1'b1;
    tick(BIT);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_frame(w[15:8], 1'b1);
    send_frame(w[7:0], 1'b1);
  endtask

  task automatic idle_bits(input int nbits);
    rx_if.uart_rx = 1'b1;
    if (nbits >= RESYNC_BITS) m_phase = 1'b0;
    tick(nbits * BIT);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_if.uart_rx = 1'b1;
    model_reset();
    tick(4);
    rst_n = 1'b1;
    tick(2 * BIT);
  endtask

  int b0, w0, f0, s0;
  logic [7:0] partial;

  initial begin
    rx_if.uart_rx = 1'b1;
    rst_n = 1'b0;
    tick(5);
    check("reset_word_out", int'(rx_if.word_out), 0);
    check("reset_idle", int'(dut.u_byte.idle_o), 1);
    rst_n = 1'b1;
    tick(2 * BIT);

    // two bytes -> one word
    b0 = n_byte; w0 = n_word;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle_bits(2);
    check("t1_bytes", n_byte - b0, 2);
    check("t1_words", n_word - w0, 1);
    check("t1_word", int'(last_word), 16'h1234);
    check("t1_last_byte", int'(last_byte), 8'h34);

    // short glitch is ignored
    b0 = n_byte; f0 = n_fe;
    rx_if.uart_rx = 1'b0;
    tick(10);
    idle_bits(2);
    check("t2_bytes", n_byte - b0, 0);
    check("t2_fe", n_fe - f0, 0);
    check("t2_idle", int'(dut.u_byte.idle_o), 1);

    // framing error drops the byte and the pending phase
    f0 = n_fe; w0 = n_word;
    send_frame(8'h99, 1'b0);
    send_frame(8'hAB, 1'b1);
    send_frame(8'hCD, 1'b1);
    idle_bits(2);
    check("t3_fe", n_fe - f0, 1);
    check("t3_words", n_word - w0, 1);
    check("t3_word", int'(last_word), 16'hABCD);

    // long idle with a half word pending resyncs
    w0 = n_word;
    send_frame(8'h11, 1'b1);
    idle_bits(25);
    send_frame(8'h56, 1'b1);
    send_frame(8'h78, 1'b1);
    idle_bits(2);
    check("t4_words", n_word - w0, 1);
    check("t4_word", int'(last_word), 16'h5678);

    // break: line held low for three frame times
    f0 = n_fe; b0 = n_byte;
    exp_fe++;
    model_reset();
    rx_if.uart_rx = 1'b0;
    tick(30 * BIT);
    idle_bits(2);
    check("t5_fe", n_fe - f0, 1);
    check("t5_bytes", n_byte - b0, 0);

    // sequence wrap
    do_reset();
    w0 = n_word; s0 = n_seq;
    send_word(16'hFFFE);
    send_word(16'hFFFF);
    send_word(16'h0000);
    send_word(16'h0002);
    idle_bits(2);
    check("t6_words", n_word - w0, 4);
    check("t6_seq_count", n_seq - s0, SEQ_EN ? 1 : 0);
    check("t6_word", int'(last_word), 16'h0002);

    // reset in the middle of data bit 4 with a half word pending
    send_frame(8'h77, 1'b1);
    partial = 8'hC3;
    rx_if.uart_rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_if.uart_rx = partial[i];
      tick(BIT);
    end
    rx_if.uart_rx = partial[4];
    tick(BIT / 2);
    do_reset();
    b0 = n_byte; w0 = n_word;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h5A, 1'b1);
    idle_bits(2);
    check("t7_bytes", n_byte - b0, 2);
    check("t7_words", n_word - w0, 1);
    check("t7_word", int'(last_word), 16'hA55A);

    check("left_bytes", exp_byte.size(), 0);
    check("left_words", exp_word.size(), 0);
    check("left_fe", exp_fe, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
